// File: rtl/finder_pkg.sv
// Shared widths, FSM state encoding and dictionary header layout for the word finder.
// Header: link lo, link hi, name length, name bytes, 2-byte parameter field.
package finder_pkg;
  localparam int ASZ = 17;
  localparam int DSZ = 8;
  localparam logic [15:0] LINK_END = 16'hFFFF;
  localparam int LNK  = 0;
  localparam int LEN  = 2;
  localparam int NAME = 3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LNK0 = 3'd1,
    S_LNK1 = 3'd2,
    S_LEN  = 3'd3,
    S_TIB  = 3'd4,
    S_NAM  = 3'd5,
    S_END  = 3'd6,
    S_DONE = 3'd7
  } state_t;
endpackage

// File: rtl/finder_if.sv
// Byte-wide memory bus: address, write data, read data (one-cycle latency) and write enable.
// The master presents ai/vi/we; the memory returns vo one cycle after ai.
interface iBus8;
  import finder_pkg::*;
  logic [ASZ-1:0] ai;
  logic [DSZ-1:0] vi;
  logic [DSZ-1:0] vo;
  logic           we;

  modport master (output ai, output vi, output we, input vo);
  modport slave  (input ai, input vi, input we, output vo);
endinterface

// File: rtl/spram8_128k.sv
// 128Kx8 single-port RAM: synchronous write when we=1, registered read (data one cycle after ai).
// A read during a write returns the previous contents.
module spram8_128k (
  input logic  clk,
  iBus8.slave  bus
);
  logic [7:0] mem [0:(1<<17)-1];

  always_ff @(posedge clk) begin
    if (bus.we) mem[bus.ai] <= bus.vi;
    bus.vo <= mem[bus.ai];
  end
endmodule

// File: rtl/finder.sv
// Walks a linked dictionary from CONTEXT comparing each header name against the NUL-terminated TIB.
// Two cycles per compared byte pair; read data is consumed one state after its address is presented.
module finder #(
  parameter int ASZ = finder_pkg::ASZ,
  parameter int DSZ = finder_pkg::DSZ
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [ASZ-1:0] aw,
  input  logic [DSZ-1:0] vw,
  output logic           bsy,
  output logic           hit,
  output logic [2:0]     st,
  output logic [ASZ-1:0] ao0,
  output logic [ASZ-1:0] ao1,
  iBus8.master           bus
);
  import finder_pkg::*;

  state_t         state_q, state_d;
  logic [ASZ-1:0] h_q, h_d, ctx_q, ctx_d, tib_q, tib_d, pfa_q, pfa_d;
  logic [7:0]     lo_q, lo_d, hi_q, hi_d, n_q, n_d, i_q, i_d;
  logic [DSZ-1:0] tb_q, tb_d;
  logic           first_q, first_d, hit_q, hit_d;
  logic [ASZ-1:0] ai_c, link;
  logic [7:0]     cnt;
  logic           follow;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      h_q     <= '0;
      ctx_q   <= '0;
      tib_q   <= '0;
      pfa_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      n_q     <= '0;
      i_q     <= '0;
      tb_q    <= '0;
      first_q <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      ctx_q   <= ctx_d;
      tib_q   <= tib_d;
      pfa_q   <= pfa_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      n_q     <= n_d;
      i_q     <= i_d;
      tb_q    <= tb_d;
      first_q <= first_d;
      hit_q   <= hit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    ctx_d   = ctx_q;
    tib_d   = tib_q;
    pfa_d   = pfa_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    n_d     = n_q;
    i_d     = i_q;
    tb_d    = tb_q;
    first_d = first_q;
    hit_d   = hit_q;
    ai_c    = '0;
    follow  = 1'b0;
    link    = ASZ'({hi_q, lo_q});
    // On the first TIB visit the length byte is still on vw, not yet in n_q.
    cnt     = first_q ? 8'(vw) : n_q;

    case (state_q)
      S_IDLE: begin
        if (en) begin
          tib_d   = aw;
          h_d     = ctx_q;
          hit_d   = 1'b0;
          state_d = S_LNK0;
        end else begin
          ctx_d = aw;
        end
      end
      S_LNK0: begin
        ai_c    = h_q + ASZ'(LNK);
        state_d = S_LNK1;
      end
      S_LNK1: begin
        ai_c    = h_q + ASZ'(LNK + 1);
        lo_d    = 8'(vw);
        state_d = S_LEN;
      end
      S_LEN: begin
        ai_c    = h_q + ASZ'(LEN);
        hi_d    = 8'(vw);
        i_d     = '0;
        first_d = 1'b1;
        state_d = S_TIB;
      end
      S_TIB: begin
        ai_c    = tib_q + ASZ'(i_q);
        first_d = 1'b0;
        if (first_q) n_d = 8'(vw);
        if (!first_q && (vw != tb_q)) follow = 1'b1;
        else if (i_q == cnt)          state_d = S_END;
        else                          state_d = S_NAM;
      end
      S_NAM: begin
        ai_c    = h_q + ASZ'(NAME) + ASZ'(i_q);
        tb_d    = vw;
        i_d     = i_q + 8'd1;
        state_d = S_TIB;
      end
      S_END: begin
        ai_c = tib_q + ASZ'(i_q);
        if (vw == '0) begin
          hit_d   = 1'b1;
          pfa_d   = h_q + ASZ'(NAME) + ASZ'(n_q);
          state_d = S_DONE;
        end else begin
          follow = 1'b1;
        end
      end
      S_DONE: ;
      default: state_d = S_IDLE;
    endcase

    if (follow) begin
      h_d     = link;
      state_d = ({hi_q, lo_q} == LINK_END) ? S_DONE : S_LNK0;
    end

    if (!en && state_q != S_IDLE) state_d = S_IDLE;
  end

  assign bsy    = (state_q != S_IDLE) && (state_q != S_DONE);
  assign hit    = hit_q;
  assign st     = state_q;
  assign ao0    = h_q;
  assign ao1    = bsy ? ai_c : pfa_q;
  assign bus.ai = ai_c;
  assign bus.vi = '0;
  assign bus.we = 1'b0;
endmodule

// File: tb/tb_finder.sv
// Directed and randomized dictionary searches checked against a string-level reference model.
module tb_finder;
  import finder_pkg::*;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           en  = 1'b0;
  logic [ASZ-1:0] aw  = '0;
  logic [DSZ-1:0] vw;
  logic           bsy, hit;
  logic [2:0]     st;
  logic [ASZ-1:0] ao0, ao1;

  logic           ld   = 1'b0;
  logic [ASZ-1:0] ld_a = '0;
  logic [7:0]     ld_d = '0;

  iBus8 dbus ();
  iBus8 mbus ();

  assign mbus.ai = ld ? ld_a : dbus.ai;
  assign mbus.we = ld;
  assign mbus.vi = ld_d;
  assign dbus.vo = mbus.vo;
  assign vw      = mbus.vo;

  finder dut (
    .clk(clk), .rst(rst), .en(en), .aw(aw), .vw(vw),
    .bsy(bsy), .hit(hit), .st(st), .ao0(ao0), .ao1(ao1), .bus(dbus)
  );

  spram8_128k ram (.clk(clk), .bus(mbus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  string          nm [8];
  logic [ASZ-1:0] haddr [8];
  int             nh;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [ASZ-1:0] a, input logic [7:0] d);
    ld_a = a;
    ld_d = d;
    ld   = 1'b1;
    @(negedge clk);
  endtask

  task automatic build_dict(input logic [ASZ-1:0] base);
    logic [ASZ-1:0] a;
    logic [15:0]    link;
    a = base;
    for (int k = 0; k < nh; k++) begin
      haddr[k] = a;
      link = (k == 0) ? 16'hFFFF : haddr[k-1][15:0];
      wr(a, link[7:0]);
      wr(a + 1, link[15:8]);
      wr(a + 2, 8'(nm[k].len()));
      for (int c = 0; c < nm[k].len(); c++) wr(a + 3 + ASZ'(c), nm[k][c]);
      wr(a + 3 + ASZ'(nm[k].len()), 8'($urandom));
      wr(a + 4 + ASZ'(nm[k].len()), 8'($urandom));
      a = a + 5 + ASZ'(nm[k].len());
    end
    ld = 1'b0;
  endtask

  task automatic write_tib(input string t);
    for (int c = 0; c < t.len(); c++) wr(ASZ'(c), t[c]);
    wr(ASZ'(t.len()), 8'h00);
    ld = 1'b0;
  endtask

  task automatic start(input logic [ASZ-1:0] ctx);
    @(negedge clk);
    en = 1'b0;
    aw = ctx;
    @(negedge clk);
    @(negedge clk);
    aw = '0;
    en = 1'b1;
    @(negedge clk);
  endtask

  task automatic search(input string tag, input string t);
    logic           e_hit;
    logic [ASZ-1:0] e_a0, e_a1;
    int             bound, n;
    e_hit = 1'b0;
    e_a0  = ASZ'(17'h0FFFF);
    e_a1  = '0;
    bound = 4;
    for (int k = nh - 1; k >= 0; k--) begin
      bound += 2 * nm[k].len() + 6;
      if (nm[k] == t) begin
        e_hit = 1'b1;
        e_a0  = haddr[k];
        e_a1  = haddr[k] + 3 + ASZ'(nm[k].len());
        break;
      end
    end
    write_tib(t);
    start(haddr[nh-1]);
    chk({tag, "/bsy_rise"}, bsy, 1);
    chk({tag, "/hit_clr"}, hit, 0);
    n = 0;
    while (st != 3'd7 && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "/done_in_bound"}, st, 7);
    chk({tag, "/bsy"}, bsy, 0);
    chk({tag, "/hit"}, hit, e_hit);
    chk({tag, "/ao0"}, ao0, e_a0);
    if (e_hit) chk({tag, "/ao1"}, ao1, e_a1);
    @(negedge clk);
    chk({tag, "/held"}, hit, e_hit);
    en = 1'b0;
    @(negedge clk);
    chk({tag, "/idle"}, st, 0);
    chk({tag, "/hit_kept"}, hit, e_hit);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    @(negedge clk);
    chk("reset/st", st, 0);
    chk("reset/bsy", bsy, 0);
    chk("reset/hit", hit, 0);
    chk("reset/ao0", ao0, 0);
    chk("reset/ao1", ao1, 0);
    chk("reset/ai", dbus.ai, 0);
    chk("reset/we", dbus.we, 0);
    @(negedge clk);
    rst = 1'b1;

    nh = 4;
    nm[0] = "abcd"; nm[1] = "efgh"; nm[2] = "ijkl"; nm[3] = "mnop";
    @(negedge clk);
    build_dict(17'h10);
    search("abcd", "abcd");
    search("ijkl", "ijkl");
    search("xyz", "xyz");
    search("abc", "abc");
    search("abcde", "abcde");
    search("empty", "");

    write_tib("xyz");
    start(haddr[nh-1]);
    repeat (7) @(negedge clk);
    chk("abort/busy", bsy, 1);
    en = 1'b0;
    @(negedge clk);
    chk("abort/st", st, 0);
    chk("abort/bsy", bsy, 0);
    search("restart", "abcd");

    write_tib("ijkl");
    start(haddr[nh-1]);
    n = 0;
    while (st != 3'd3 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst/reach_len", st, 3);
    #2 rst = 1'b0;
    #1;
    chk("rst/st", st, 0);
    chk("rst/bsy", bsy, 0);
    chk("rst/hit", hit, 0);
    chk("rst/ao0", ao0, 0);
    chk("rst/ao1", ao1, 0);
    chk("rst/ai", dbus.ai, 0);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst/idle_st", st, 0);
    chk("rst/idle_bsy", bsy, 0);
    search("after_rst", "ijkl");

    for (int it = 0; it < 25; it++) begin
      string t;
      nh = $urandom_range(1, 6);
      for (int k = 0; k < nh; k++) begin
        nm[k] = "";
        for (int c = 0, l = $urandom_range(0, 3); c < l; c++)
          nm[k] = {nm[k], ($urandom_range(0, 1) != 0) ? "a" : "b"};
      end
      if ($urandom_range(0, 1) != 0) begin
        t = nm[$urandom_range(0, nh - 1)];
      end else begin
        t = "";
        for (int c = 0, l = $urandom_range(0, 3); c < l; c++)
          t = {t, ($urandom_range(0, 1) != 0) ? "a" : "b"};
      end
      build_dict(ASZ'(17'h40 + $urandom_range(0, 64)));
      search($sformatf("rand%0d", it), t);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
